// File: rtl/acc_pkg.sv
// acc_pkg: shared types and constants for the accumulator slice.
//   ACC_W       datapath width of A and B (fixed at 8 by the zero detector)
//   op_t        operation codes 000..111
//   acc_state_t control states of the multiply sequencer
//   MUL_CYCLES  iteration count of the shift-add multiply
//   acc_alu     single-cycle result {C, A} for every non-multiply op
package acc_pkg;

  localparam int ACC_W      = 8;
  localparam int MUL_CYCLES = 8;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_AND  = 3'b011,
    OP_OR   = 3'b100,
    OP_XOR  = 3'b101,
    OP_SHL  = 3'b110,
    OP_MUL  = 3'b111
  } op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } acc_state_t;

  // Returns {C, A}. OP_MUL is not computed here; it returns the inputs
  // unchanged so the caller gets NOP behaviour for free.
  function automatic logic [ACC_W:0] acc_alu(input op_t op,
                                             input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b,
                                             input logic c_in);
    logic [ACC_W:0] res;
    res = {c_in, a};
    case (op)
      OP_LOAD: res = {1'b0, b};
      OP_ADD:  res = {1'b0, a} + {1'b0, b};
      // 9-bit difference: bit 8 is set exactly when a < b
      OP_SUB:  res = {1'b0, a} - {1'b0, b};
      OP_AND:  res = {1'b0, a & b};
      OP_OR:   res = {1'b0, a | b};
      OP_XOR:  res = {1'b0, a ^ b};
      OP_SHL:  res = {a, 1'b0};
      OP_MUL:  res = {c_in, a};
      default: res = {c_in, a};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/acc_mul_seq.sv
// acc_mul_seq: 8-iteration shift-add multiplier (LSB-first).
//   clk, rst_n  clock, async active-low reset
//   start       latch operands and clear counter/partial product
//   run         iterate one multiplier bit this cycle
//   mcand       multiplicand (A at accept)
//   mplier      multiplier (B at accept)
//   product     partial product after the current iteration (combinational)
//   finish      high during the last iteration; product is then final
module acc_mul_seq
  import acc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 run,
  input  logic [ACC_W-1:0]     mcand,
  input  logic [ACC_W-1:0]     mplier,
  output logic [2*ACC_W-1:0]   product,
  output logic                 finish
);

  logic [2*ACC_W-1:0] mcand_r;
  logic [2*ACC_W-1:0] prod_r;
  logic [ACC_W-1:0]   mplier_r;
  logic [2:0]         cnt_r;
  logic [2*ACC_W-1:0] prod_nxt_s;

  // Add the shifted multiplicand when the current multiplier bit is set
  always_comb begin
    prod_nxt_s = prod_r;
    if (mplier_r[0]) begin
      prod_nxt_s = prod_r + mcand_r;
    end else begin
      prod_nxt_s = prod_r;
    end
  end

  // Operand latch and iteration registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r  <= {(2*ACC_W){1'b0}};
      prod_r   <= {(2*ACC_W){1'b0}};
      mplier_r <= {ACC_W{1'b0}};
      cnt_r    <= 3'd0;
    end else if (start) begin
      mcand_r  <= {{ACC_W{1'b0}}, mcand};
      prod_r   <= {(2*ACC_W){1'b0}};
      mplier_r <= mplier;
      cnt_r    <= 3'd0;
    end else if (run) begin
      prod_r   <= prod_nxt_s;
      mcand_r  <= mcand_r << 1;
      mplier_r <= mplier_r >> 1;
      // wraps 7 -> 0 on the final iteration, leaving it ready for the next run
      cnt_r    <= cnt_r + 3'd1;
    end
  end

  assign product = prod_nxt_s;
  assign finish  = run && (cnt_r == 3'(MUL_CYCLES - 1));

endmodule

// File: rtl/acc_unit.sv
// acc_unit: 8-bit accumulator stage feeding the zero detector.
//   clk, rst_n  clock, async active-low reset
//   op_valid    command present
//   op_ready    unit can accept (decode of IDLE state, no op_valid path)
//   op          operation code (see acc_pkg::op_t)
//   B_in        operand, sampled at accept
//   A_out       accumulator register
//   C_out       carry/borrow/overflow flag register
//   done        one-cycle pulse when a result lands in A_out
// Build option: define ACC_MUL_EN for the 8-cycle shift-add multiply;
// without it op 111 is a single-cycle NOP and op_ready is tied high.
module acc_unit
  import acc_pkg::*;
#(
  parameter int WIDTH = ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] B_in,
  output logic [WIDTH-1:0] A_out,
  output logic             C_out,
  output logic             done
);

  logic [WIDTH-1:0] a_r, a_nxt_s;
  logic             c_r, c_nxt_s;
  logic             done_r, done_nxt_s;
  logic             accept_s;
  logic [WIDTH:0]   alu_s;

  assign accept_s = op_valid && op_ready;

`ifdef ACC_MUL_EN
  acc_state_t           state_r, state_nxt_s;
  logic                 mul_start_s;
  logic                 mul_run_s;
  logic                 mul_last_s;
  logic [2*WIDTH-1:0]   mul_prod_s;

  assign op_ready  = (state_r == ST_IDLE);
  assign mul_run_s = (state_r == ST_MUL);

  acc_mul_seq u_mul_seq (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (mul_start_s),
    .run     (mul_run_s),
    .mcand   (a_r),
    .mplier  (B_in),
    .product (mul_prod_s),
    .finish  (mul_last_s)
  );

  // Next-state and next-result decode; A/C hold while a multiply runs
  always_comb begin
    a_nxt_s     = a_r;
    c_nxt_s     = c_r;
    done_nxt_s  = 1'b0;
    state_nxt_s = state_r;
    mul_start_s = 1'b0;
    alu_s       = acc_alu(op_t'(op), a_r, B_in, c_r);
    case (state_r)
      ST_IDLE: begin
        if (accept_s && (op_t'(op) == OP_MUL)) begin
          mul_start_s = 1'b1;
          state_nxt_s = ST_MUL;
        end else if (accept_s) begin
          a_nxt_s    = alu_s[WIDTH-1:0];
          c_nxt_s    = alu_s[WIDTH];
          done_nxt_s = 1'b1;
        end else begin
          done_nxt_s = 1'b0;
        end
      end
      ST_MUL: begin
        if (mul_last_s) begin
          a_nxt_s     = mul_prod_s[WIDTH-1:0];
          c_nxt_s     = |mul_prod_s[2*WIDTH-1:WIDTH];
          done_nxt_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_MUL;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Control state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end
`else
  assign op_ready = 1'b1;

  // Single-cycle decode; op 111 falls through acc_alu as a NOP that still pulses done
  always_comb begin
    a_nxt_s    = a_r;
    c_nxt_s    = c_r;
    done_nxt_s = 1'b0;
    alu_s      = acc_alu(op_t'(op), a_r, B_in, c_r);
    if (accept_s) begin
      a_nxt_s    = alu_s[WIDTH-1:0];
      c_nxt_s    = alu_s[WIDTH];
      done_nxt_s = 1'b1;
    end else begin
      done_nxt_s = 1'b0;
    end
  end
`endif

  // Accumulator, flag and done registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= {WIDTH{1'b0}};
      c_r    <= 1'b0;
      done_r <= 1'b0;
    end else begin
      a_r    <= a_nxt_s;
      c_r    <= c_nxt_s;
      done_r <= done_nxt_s;
    end
  end

  assign A_out = a_r;
  assign C_out = c_r;
  assign done  = done_r;

endmodule

// File: tb/tb_acc_unit.sv
// tb_acc_unit: directed-vector bench for acc_unit. Expected values are
// hand-computed constants. Multiply checks are compiled in with ACC_MUL_EN,
// otherwise op 111 is checked as a NOP.
module tb_acc_unit;

  logic       clk;
  logic       rst_n;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op;
  logic [7:0] B_in;
  logic [7:0] A_out;
  logic       C_out;
  logic       done;

  int vec_cnt;
  int err_cnt;

  acc_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op       (op),
    .B_in     (B_in),
    .A_out    (A_out),
    .C_out    (C_out),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] observed,
                          input logic [15:0] expected);
    vec_cnt = vec_cnt + 1;
    if (observed !== expected) begin
      err_cnt = err_cnt + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [7:0] b);
    op_valid = 1'b1;
    op       = o;
    B_in     = b;
  endtask

  task automatic idle();
    op_valid = 1'b0;
    op       = 3'b000;
    B_in     = 8'h00;
  endtask

  // one accepted single-cycle op, then check A, C and done
  task automatic do_op(input string tag, input logic [2:0] o, input logic [7:0] b,
                       input logic [7:0] exp_a, input logic exp_c);
    drive(o, b);
    step();
    idle();
    check_eq({tag, "_a"}, {8'h00, A_out}, {8'h00, exp_a});
    check_eq({tag, "_c"}, {15'h0, C_out}, {15'h0, exp_c});
    check_eq({tag, "_done"}, {15'h0, done}, 16'h0001);
  endtask

  initial begin
    int dones;
    int lat;
    vec_cnt  = 0;
    err_cnt  = 0;
    rst_n    = 1'b0;
    op_valid = 1'b0;
    op       = 3'b000;
    B_in     = 8'h00;

    // reset state
    #12;
    check_eq("rst_a",     {8'h00, A_out}, 16'h0000);
    check_eq("rst_c",     {15'h0, C_out}, 16'h0000);
    check_eq("rst_done",  {15'h0, done},  16'h0000);
    check_eq("rst_ready", {15'h0, op_ready}, 16'h0001);
    check_eq("rst_zero",  {15'h0, (A_out == 8'h00)}, 16'h0001);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("idle_a",    {8'h00, A_out}, 16'h0000);
    check_eq("idle_ready", {15'h0, op_ready}, 16'h0001);

    // back-to-back LOAD then ADD with carry out
    drive(3'b000, 8'hF0);
    step();
    check_eq("b2b_load_a", {8'h00, A_out}, 16'h00F0);
    check_eq("b2b_load_c", {15'h0, C_out}, 16'h0000);
    check_eq("b2b_load_done", {15'h0, done}, 16'h0001);
    drive(3'b001, 8'h20);
    step();
    idle();
    check_eq("b2b_add_a", {8'h00, A_out}, 16'h0010);
    check_eq("b2b_add_c", {15'h0, C_out}, 16'h0001);
    check_eq("b2b_add_done", {15'h0, done}, 16'h0001);
    step();
    check_eq("done_clear", {15'h0, done}, 16'h0000);
    check_eq("hold_a", {8'h00, A_out}, 16'h0010);

    // subtract to zero, then borrow
    do_op("ld05",  3'b000, 8'h05, 8'h05, 1'b0);
    do_op("sub05", 3'b010, 8'h05, 8'h00, 1'b0);
    check_eq("sub_zero", {15'h0, (A_out == 8'h00)}, 16'h0001);
    do_op("sub01", 3'b010, 8'h01, 8'hFF, 1'b1);

    // shift out the MSB, then XOR to zero
    do_op("ld81",  3'b000, 8'h81, 8'h81, 1'b0);
    do_op("shl",   3'b110, 8'hFF, 8'h02, 1'b1);
    do_op("xor02", 3'b101, 8'h02, 8'h00, 1'b0);

    // AND / OR
    do_op("ld3c",  3'b000, 8'h3C, 8'h3C, 1'b0);
    do_op("and0f", 3'b011, 8'h0F, 8'h0C, 1'b0);
    do_op("ora0",  3'b100, 8'hA0, 8'hAC, 1'b0);

`ifdef ACC_MUL_EN
    // MUL 0x12 * 0x34 = 0x3A8, with a held ADD 0x01 behind it
    do_op("ld12", 3'b000, 8'h12, 8'h12, 1'b0);
    drive(3'b111, 8'h34);
    step();
    drive(3'b001, 8'h01);
    dones = 0;
    for (int i = 1; i <= 7; i++) begin
      check_eq("mul_ready", {15'h0, op_ready}, 16'h0000);
      check_eq("mul_hold_a", {8'h00, A_out}, 16'h0012);
      if (done) dones = dones + 1;
      step();
    end
    check_eq("mul_ready7", {15'h0, op_ready}, 16'h0000);
    check_eq("mul_early_done", dones[15:0], 16'h0000);
    step();
    check_eq("mul_a", {8'h00, A_out}, 16'h00A8);
    check_eq("mul_c", {15'h0, C_out}, 16'h0001);
    check_eq("mul_done", {15'h0, done}, 16'h0001);
    check_eq("mul_ready_up", {15'h0, op_ready}, 16'h0001);
    step();
    idle();
    check_eq("held_add_a", {8'h00, A_out}, 16'h00A9);
    check_eq("held_add_c", {15'h0, C_out}, 16'h0000);
    check_eq("held_add_done", {15'h0, done}, 16'h0001);

    // multiply by zero keeps the fixed latency
    do_op("ld55", 3'b000, 8'h55, 8'h55, 1'b0);
    drive(3'b111, 8'h00);
    step();
    idle();
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (lat == 0) begin
        step();
        if (done) lat = i;
      end
    end
    check_eq("mul0_latency", lat[15:0], 16'd8);
    check_eq("mul0_a", {8'h00, A_out}, 16'h0000);
    check_eq("mul0_c", {15'h0, C_out}, 16'h0000);

    // reset at iteration 4 aborts the multiply
    do_op("ld07", 3'b000, 8'h07, 8'h07, 1'b0);
    drive(3'b111, 8'h03);
    step();
    idle();
    for (int i = 1; i <= 4; i++) step();
`else
    // op 111 is a single-cycle NOP; prime C=1 first
    do_op("ldff", 3'b000, 8'hFF, 8'hFF, 1'b0);
    do_op("add01", 3'b001, 8'h01, 8'h00, 1'b1);
    do_op("ld5a", 3'b000, 8'h5A, 8'h5A, 1'b0);
    do_op("add00", 3'b001, 8'hA6, 8'h00, 1'b1);
    do_op("nop", 3'b111, 8'h33, 8'h00, 1'b1);
    check_eq("nop_ready", {15'h0, op_ready}, 16'h0001);
    step();
    check_eq("nop_done_clear", {15'h0, done}, 16'h0000);
    do_op("ld07", 3'b000, 8'h07, 8'h07, 1'b0);
    do_op("nop2", 3'b111, 8'h00, 8'h07, 1'b0);
    drive(3'b111, 8'h03);
    step();
    idle();
`endif

    // asynchronous reset pulse
    rst_n = 1'b0;
    #1;
    check_eq("arst_a", {8'h00, A_out}, 16'h0000);
    check_eq("arst_c", {15'h0, C_out}, 16'h0000);
    check_eq("arst_done", {15'h0, done}, 16'h0000);
    check_eq("arst_ready", {15'h0, op_ready}, 16'h0001);
    step();
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) dones = dones + 1;
    end
    check_eq("arst_no_done", dones[15:0], 16'h0000);
    check_eq("arst_a_after", {8'h00, A_out}, 16'h0000);
    check_eq("arst_ready_after", {15'h0, op_ready}, 16'h0001);

    // unit is usable after the abort
    do_op("post_ld", 3'b000, 8'h9C, 8'h9C, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
